// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
// Control FSM for a multicycle MIPS-style datapath. Each instruction passes
// through FETCH -> DECODE -> EXEC and then, depending on its class, through
// MEM and/or WB. Illegal opcodes or R-type functs park the FSM in TRAP until
// reset.
//
// Ports
//   Clk          : system clock, rising edge active
//   Rst          : asynchronous reset, active low
//   oprtn, fcn   : opcode / funct fields of the instruction register
//   Zero         : ALU zero flag (drives PCWrt for beq in EXEC)
//   MemRdy       : memory access completes this cycle
//   PCWrt, IRWrt : PC / instruction register write enables
//   MemRd, MemWrt: memory read / write strobes
//   RgWrt, destReg, MemtReg, ALUSc, Bnch, Jmp : datapath selects
//   ALUOperation : 4-bit ALU control code
//   Err          : sticky illegal-instruction flag
//   InstrCnt     : retired instruction counter (wraps)
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [5:0]       oprtn,
    input  logic [5:0]       fcn,
    input  logic             Zero,
    input  logic             MemRdy,
    output logic             PCWrt,
    output logic             IRWrt,
    output logic             MemRd,
    output logic             MemWrt,
    output logic             RgWrt,
    output logic             destReg,
    output logic             MemtReg,
    output logic             ALUSc,
    output logic             Bnch,
    output logic             Jmp,
    output logic [3:0]       ALUOperation,
    output logic             Err,
    output logic [CNT_W-1:0] InstrCnt
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] TRAP   = 3'd5;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    logic [2:0] state, next_state;
    logic [5:0] op_q, fn_q;
    logic       legal;
    logic       retire;

    // Legality is judged on the live IR fields while in DECODE, before they
    // are captured into op_q/fn_q.
    always_comb begin
        legal = 1'b0;
        case (oprtn)
            OP_R: begin
                case (fcn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
                    default:                               legal = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:  next_state = MemRdy ? DECODE : FETCH;
            DECODE: next_state = legal ? EXEC : TRAP;
            EXEC: begin
                case (op_q)
                    OP_LW, OP_SW:  next_state = MEM;
                    OP_BEQ, OP_J:  next_state = FETCH;
                    default:       next_state = WB;
                endcase
            end
            MEM: begin
                if (MemRdy) begin
                    next_state = (op_q == OP_LW) ? WB : FETCH;
                end
            end
            WB:      next_state = FETCH;
            TRAP:    next_state = TRAP;
            default: next_state = FETCH;
        endcase
    end

    // The last cycle of an instruction depends on its class: EXEC for
    // branches/jumps, MEM completion for sw, WB for everything else.
    assign retire = ((state == EXEC) && ((op_q == OP_BEQ) || (op_q == OP_J)))
                  || ((state == MEM) && MemRdy && (op_q == OP_SW))
                  || (state == WB);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= FETCH;
            op_q     <= '0;
            fn_q     <= '0;
            InstrCnt <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE) begin
                op_q <= oprtn;
                fn_q <= fcn;
            end
            if (retire) begin
                InstrCnt <= InstrCnt + CNT_W'(1);
            end
        end
    end

    // Outputs are gated by Rst so that nothing strobes while reset is held,
    // even though the reset state is FETCH (which would otherwise issue MemRd).
    always_comb begin
        PCWrt        = 1'b0;
        IRWrt        = 1'b0;
        MemRd        = 1'b0;
        MemWrt       = 1'b0;
        RgWrt        = 1'b0;
        destReg      = 1'b0;
        MemtReg      = 1'b0;
        ALUSc        = 1'b0;
        Bnch         = 1'b0;
        Jmp          = 1'b0;
        ALUOperation = 4'b0000;
        Err          = 1'b0;
        if (Rst) begin
            case (state)
                FETCH: begin
                    MemRd = 1'b1;
                    IRWrt = MemRdy;
                    PCWrt = MemRdy;
                end
                EXEC: begin
                    case (op_q)
                        OP_LW, OP_SW, OP_ADDI: begin
                            ALUOperation = 4'b0010;
                            ALUSc        = 1'b1;
                        end
                        OP_BEQ: begin
                            ALUOperation = 4'b0110;
                            Bnch         = 1'b1;
                            PCWrt        = Zero;
                        end
                        OP_J: begin
                            Jmp   = 1'b1;
                            PCWrt = 1'b1;
                        end
                        OP_R: begin
                            case (fn_q)
                                FN_ADD:  ALUOperation = 4'b0010;
                                FN_SUB:  ALUOperation = 4'b0110;
                                FN_AND:  ALUOperation = 4'b0000;
                                FN_OR:   ALUOperation = 4'b0001;
                                FN_SLT:  ALUOperation = 4'b0111;
                                default: ALUOperation = 4'b0000;
                            endcase
                        end
                        default: ALUOperation = 4'b0000;
                    endcase
                end
                MEM: begin
                    MemRd  = (op_q == OP_LW);
                    MemWrt = (op_q == OP_SW);
                end
                WB: begin
                    RgWrt   = 1'b1;
                    destReg = (op_q == OP_R);
                    MemtReg = (op_q == OP_LW);
                end
                TRAP:    Err = 1'b1;
                default: Err = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer
// Directed bench for multicycle_sequencer. Two instances share all inputs:
// one with the default 16-bit counter and one with a 4-bit counter so that
// counter wrap can be observed. Outputs are packed into a control vector and
// sampled one time unit after the falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_sequencer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [5:0]  oprtn;
    logic [5:0]  fcn;
    logic        Zero;
    logic        MemRdy;

    logic        PCWrt, IRWrt, MemRd, MemWrt, RgWrt, destReg, MemtReg;
    logic        ALUSc, Bnch, Jmp, Err;
    logic [3:0]  ALUOperation;
    logic [15:0] InstrCnt;

    logic        PCWrt4, IRWrt4, MemRd4, MemWrt4, RgWrt4, destReg4, MemtReg4;
    logic        ALUSc4, Bnch4, Jmp4, Err4;
    logic [3:0]  ALUOperation4;
    logic [3:0]  InstrCnt4;

    logic [14:0] ctrl;

    int num_checks = 0;
    int num_errors = 0;
    int exp_cnt    = 0;

    // Packed order: PCWrt IRWrt MemRd MemWrt RgWrt destReg MemtReg ALUSc Bnch Jmp Err ALUOperation
    localparam logic [14:0] V_IDLE   = 15'b0_0_0_0_0_0_0_0_0_0_0_0000;
    localparam logic [14:0] V_FETCH  = 15'b1_1_1_0_0_0_0_0_0_0_0_0000;
    localparam logic [14:0] V_MEMRD  = 15'b0_0_1_0_0_0_0_0_0_0_0_0000;
    localparam logic [14:0] V_MEMWR  = 15'b0_0_0_1_0_0_0_0_0_0_0_0000;
    localparam logic [14:0] V_WB_R   = 15'b0_0_0_0_1_1_0_0_0_0_0_0000;
    localparam logic [14:0] V_WB_I   = 15'b0_0_0_0_1_0_0_0_0_0_0_0000;
    localparam logic [14:0] V_WB_LW  = 15'b0_0_0_0_1_0_1_0_0_0_0_0000;
    localparam logic [14:0] V_EX_IMM = 15'b0_0_0_0_0_0_0_1_0_0_0_0010;
    localparam logic [14:0] V_EX_J   = 15'b1_0_0_0_0_0_0_0_0_1_0_0000;
    localparam logic [14:0] V_TRAP   = 15'b0_0_0_0_0_0_0_0_0_0_1_0000;

    assign ctrl = {PCWrt, IRWrt, MemRd, MemWrt, RgWrt, destReg, MemtReg,
                   ALUSc, Bnch, Jmp, Err, ALUOperation};

    multicycle_sequencer dut (
        .Clk(Clk), .Rst(Rst), .oprtn(oprtn), .fcn(fcn), .Zero(Zero), .MemRdy(MemRdy),
        .PCWrt(PCWrt), .IRWrt(IRWrt), .MemRd(MemRd), .MemWrt(MemWrt), .RgWrt(RgWrt),
        .destReg(destReg), .MemtReg(MemtReg), .ALUSc(ALUSc), .Bnch(Bnch), .Jmp(Jmp),
        .ALUOperation(ALUOperation), .Err(Err), .InstrCnt(InstrCnt)
    );

    multicycle_sequencer #(.CNT_W(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .oprtn(oprtn), .fcn(fcn), .Zero(Zero), .MemRdy(MemRdy),
        .PCWrt(PCWrt4), .IRWrt(IRWrt4), .MemRd(MemRd4), .MemWrt(MemWrt4), .RgWrt(RgWrt4),
        .destReg(destReg4), .MemtReg(MemtReg4), .ALUSc(ALUSc4), .Bnch(Bnch4), .Jmp(Jmp4),
        .ALUOperation(ALUOperation4), .Err(Err4), .InstrCnt(InstrCnt4)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Called right after a falling edge: drive handshake inputs, let the
    // combinational outputs settle, compare, then advance to the next falling edge.
    task automatic applyStimulus(input string tag, input logic rdy, input logic z,
                                 input logic [14:0] expected);
        MemRdy = rdy;
        Zero   = z;
        #1;
        checkOutput(tag, 32'(ctrl), 32'(expected));
        @(negedge Clk);
    endtask

    task automatic checkCount(input string tag);
        checkOutput(tag, 32'(InstrCnt), 32'(exp_cnt & 16'hFFFF));
        checkOutput({tag, "_w4"}, 32'(InstrCnt4), 32'(exp_cnt & 4'hF));
    endtask

    task automatic applyReset();
        Rst = 1'b0;
        #1;
        checkOutput("rst_ctrl", 32'(ctrl), 32'(V_IDLE));
        exp_cnt = 0;
        checkCount("rst_cnt");
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic runRtype(input logic [5:0] f, input logic [3:0] alu);
        oprtn = 6'b000000;
        fcn   = f;
        applyStimulus("r_fetch", 1'b1, 1'b0, V_FETCH);
        applyStimulus("r_decode", 1'b1, 1'b0, V_IDLE);
        applyStimulus("r_exec", 1'b1, 1'b0, {11'b0, alu});
        applyStimulus("r_wb", 1'b1, 1'b0, V_WB_R);
        exp_cnt++;
        checkCount("r_cnt");
    endtask

    task automatic runBeq(input logic z);
        oprtn = 6'b000100;
        fcn   = 6'b000000;
        applyStimulus("beq_fetch", 1'b1, 1'b0, V_FETCH);
        applyStimulus("beq_decode", 1'b1, 1'b0, V_IDLE);
        applyStimulus("beq_exec", 1'b1, z, {z, 14'b00000001000110});
        exp_cnt++;
        checkCount("beq_cnt");
    endtask

    task automatic runJump();
        oprtn = 6'b000010;
        fcn   = 6'b000000;
        applyStimulus("j_fetch", 1'b1, 1'b0, V_FETCH);
        applyStimulus("j_decode", 1'b1, 1'b0, V_IDLE);
        applyStimulus("j_exec", 1'b1, 1'b0, V_EX_J);
        exp_cnt++;
        checkCount("j_cnt");
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Rst    = 1'b0;
        oprtn  = 6'b0;
        fcn    = 6'b0;
        Zero   = 1'b0;
        MemRdy = 1'b1;
        applyReset();

        // R-type: add, sub, and, or, slt
        runRtype(6'b100000, 4'b0010);
        runRtype(6'b100010, 4'b0110);
        runRtype(6'b100100, 4'b0000);
        runRtype(6'b100101, 4'b0001);
        runRtype(6'b101010, 4'b0111);

        // addi
        oprtn = 6'b001000;
        applyStimulus("addi_fetch", 1'b1, 1'b0, V_FETCH);
        applyStimulus("addi_decode", 1'b1, 1'b0, V_IDLE);
        applyStimulus("addi_exec", 1'b1, 1'b0, V_EX_IMM);
        applyStimulus("addi_wb", 1'b1, 1'b0, V_WB_I);
        exp_cnt++;
        checkCount("addi_cnt");

        // lw with three wait cycles in MEM: 8 cycles total
        oprtn = 6'b100011;
        applyStimulus("lw_fetch", 1'b1, 1'b0, V_FETCH);
        applyStimulus("lw_decode", 1'b1, 1'b0, V_IDLE);
        applyStimulus("lw_exec", 1'b1, 1'b0, V_EX_IMM);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("lw_mem_wait", 1'b0, 1'b0, V_MEMRD);
        end
        applyStimulus("lw_mem_done", 1'b1, 1'b0, V_MEMRD);
        applyStimulus("lw_wb", 1'b1, 1'b0, V_WB_LW);
        exp_cnt++;
        checkCount("lw_cnt");

        // sw, no wait
        oprtn = 6'b101011;
        applyStimulus("sw_fetch", 1'b1, 1'b0, V_FETCH);
        applyStimulus("sw_decode", 1'b1, 1'b0, V_IDLE);
        applyStimulus("sw_exec", 1'b1, 1'b0, V_EX_IMM);
        applyStimulus("sw_mem", 1'b1, 1'b0, V_MEMWR);
        exp_cnt++;
        checkCount("sw_cnt");

        // beq not taken then taken
        runBeq(1'b0);
        runBeq(1'b1);

        // j preceded by a fetch wait cycle
        oprtn = 6'b000010;
        applyStimulus("fetch_wait", 1'b0, 1'b0, V_MEMRD);
        runJump();

        // Reset asserted while sw waits in MEM: strobes drop without a clock edge
        oprtn = 6'b101011;
        applyStimulus("sw2_fetch", 1'b1, 1'b0, V_FETCH);
        applyStimulus("sw2_decode", 1'b1, 1'b0, V_IDLE);
        applyStimulus("sw2_exec", 1'b1, 1'b0, V_EX_IMM);
        MemRdy = 1'b0;
        #1;
        checkOutput("sw2_mem_wait", 32'(ctrl), 32'(V_MEMWR));
        #1;
        Rst = 1'b0;
        #1;
        checkOutput("async_rst_ctrl", 32'(ctrl), 32'(V_IDLE));
        exp_cnt = 0;
        checkCount("async_rst_cnt");
        @(negedge Clk);
        Rst = 1'b1;
        applyStimulus("post_rst_fetch", 1'b1, 1'b0, V_FETCH);
        applyStimulus("post_rst_decode", 1'b1, 1'b0, V_IDLE);
        applyStimulus("post_rst_exec", 1'b1, 1'b0, V_EX_IMM);
        applyStimulus("post_rst_mem", 1'b1, 1'b0, V_MEMWR);
        exp_cnt++;
        checkCount("post_rst_cnt");

        // Illegal opcode: TRAP for 20 cycles, counter frozen
        runJump();
        oprtn = 6'b111111;
        applyStimulus("ill_fetch", 1'b1, 1'b0, V_FETCH);
        applyStimulus("ill_decode", 1'b1, 1'b0, V_IDLE);
        for (int i = 0; i < 20; i++) begin
            applyStimulus("ill_trap", (i % 2) == 0, 1'b1, V_TRAP);
        end
        checkCount("ill_cnt");
        applyReset();
        applyStimulus("ill_recover_fetch", 1'b1, 1'b0, V_FETCH);

        // Illegal R-type funct
        applyReset();
        oprtn = 6'b000000;
        fcn   = 6'b000000;
        applyStimulus("badfn_fetch", 1'b1, 1'b0, V_FETCH);
        applyStimulus("badfn_decode", 1'b1, 1'b0, V_IDLE);
        applyStimulus("badfn_trap", 1'b1, 1'b0, V_TRAP);
        applyStimulus("badfn_trap2", 1'b1, 1'b0, V_TRAP);
        checkCount("badfn_cnt");

        // 16 jumps: 4-bit counter wraps 1111 -> 0000, 16-bit reaches 16
        applyReset();
        for (int i = 0; i < 16; i++) begin
            runJump();
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, setting the retired-instruction counter width.
REQ-002 Port Clk  input  1  single system clock; all state changes occur on its rising edge.
REQ-003 Port Rst  input  1  asynchronous, active-low reset (Rst=0 resets).
REQ-004 Port oprtn  input  6  opcode field of the instruction register.
REQ-005 Port fcn  input  6  function field of the instruction register.
REQ-006 Port Zero  input  1  ALU zero flag from the datapath.
REQ-007 Port MemRdy  input  1  memory ready; 1 means the current memory access completes this cycle.
REQ-008 Port PCWrt  output  1  PC write enable.
REQ-009 Port IRWrt  output  1  instruction register write enable.
REQ-010 Port MemRd, MemWrt  output  1 each  memory read and write strobes.
REQ-011 Port RgWrt, destReg, MemtReg, ALUSc, Bnch, Jmp  output  1 each  register write, rd/rt select, memory-to-register select, immediate select, branch select, jump select.
REQ-012 Port ALUOperation  output  4  ALU control code.
REQ-013 Port Err  output  1  sticky illegal-instruction flag.
REQ-014 Port InstrCnt  output  CNT_W  count of retired instructions.

Function
REQ-015 The state register SHALL use the states FETCH, DECODE, EXEC, MEM, WB and TRAP, and all outputs SHALL be combinational functions of the state and the latched oprtn/fcn (Moore-style, no input-to-output paths except MemRdy and Zero where stated).
REQ-016 FETCH SHALL assert MemRd and hold while MemRdy=0, and on MemRdy=1 SHALL assert IRWrt and PCWrt for that cycle and move to DECODE.
REQ-017 DECODE SHALL latch oprtn/fcn internally and go to EXEC for the legal opcodes 000000 (R-type), 100011 (lw), 101011 (sw), 000100 (beq), 001000 (addi) and 000010 (j), and to TRAP for any other opcode or for an R-type funct outside {100000, 100010, 100100, 100101, 101010}.
REQ-018 In EXEC, ALUOperation SHALL be: add 0010 for lw, sw and addi; sub 0110 for beq; for R-type, 0010/0110/0000/0001/0111 for funct add/sub/and/or/slt respectively.
REQ-019 In EXEC, ALUSc SHALL be 1 for lw, sw and addi and 0 otherwise.
REQ-020 In EXEC for beq, Bnch=1 and PCWrt=Zero, followed by a return to FETCH.
REQ-021 In EXEC for j, Jmp=1 and PCWrt=1, followed by a return to FETCH.
REQ-022 From EXEC, lw and sw SHALL go to MEM, and R-type and addi SHALL go to WB.
REQ-023 MEM SHALL assert MemRd (lw) or MemWrt (sw) and hold while MemRdy=0; on MemRdy=1, lw goes to WB and sw goes to FETCH.
REQ-024 WB SHALL assert RgWrt=1 for one cycle, with destReg=1 for R-type only and MemtReg=1 for lw only, and then go to FETCH.
REQ-025 Outputs not listed for a state SHALL be 0 in that state.
REQ-026 Cycle counts with MemRdy tied high SHALL be: beq and j 3 cycles; R-type, addi and sw 4 cycles; lw 5 cycles.
REQ-027 InstrCnt SHALL increment by 1 on the final cycle of each legal instruction and wrap from all-ones to 0.
REQ-028 TRAP SHALL set Err=1, hold all strobes at 0, not increment InstrCnt, and be left only by reset.
REQ-029 MemRd and MemWrt SHALL never be asserted in the same cycle.
REQ-030 PCWrt SHALL be asserted at most once in FETCH and at most once in EXEC per instruction.

Reset
REQ-031 Rst=0 SHALL immediately force state=FETCH, InstrCnt=0, Err=0 and the latched opcode/funct to 0, regardless of Clk or the current state (including mid-MEM wait).
REQ-032 During and after reset, IRWrt, PCWrt, MemWrt and RgWrt SHALL be 0, and MemRd SHALL be 1 only once Rst=1 (FETCH issuing).
REQ-033 The first fetch SHALL begin on the first rising Clk after Rst deasserts.

Verification
REQ-034 R-type add (oprtn=000000, fcn=100000), MemRdy=1 -> FETCH/DECODE/EXEC(ALUOperation=0010, ALUSc=0)/WB(RgWrt=1, destReg=1), and InstrCnt 0->1 after 4 cycles.
REQ-035 lw with MemRdy low for 3 cycles in MEM -> MemRd held 4 cycles, then WB with MemtReg=1, and 8 cycles total.
REQ-036 beq with Zero=0 then with Zero=1 -> EXEC PCWrt=0 then 1, Bnch=1 in both, and 3 cycles each.
REQ-037 Illegal opcode 111111 -> TRAP, Err=1, all strobes 0 for 20 cycles, InstrCnt unchanged; Rst=0 pulse -> Err=0, state=FETCH.
REQ-038 Rst=0 asserted mid-MEM of sw with MemWrt=1 -> MemWrt drops to 0 without a Clk edge and InstrCnt=0.
REQ-039 CNT_W=4 with 16 consecutive j instructions -> InstrCnt wraps 1111->0000.
